mc_ctrl: RTL and testbench

Multi-cycle main controller that sequences the shared 32-bit ALU, register file, PC and unified memory of the mipslite core.
- Decodes op/funct from the instruction register.
- Steps a Moore FSM through fetch/decode/execute/memory/writeback.
- Drives alu_cont with the shared ALU control encodings, plus all datapath mux selects and write strobes.
- Stalls on a memory ready handshake.

---
 rtl/mc_ctrl_pkg.sv | 98 +++++++++
 rtl/mc_alu_dec.sv | 51 +++++
 rtl/mc_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants and types for the mipslite multi-cycle
// controller.
//   - ALU_CONTROL_LENGTH / ALU_CONTROL_*: ALU operation encodings driven on alu_cont
//   - OP_* / FUNCT_*   : opcode (IR[31:26]) and funct (IR[5:0]) values decoded
//   - ALUSRCB_*        : ALU B-input mux selects
//   - PCSRC_*          : PC source mux selects
//   - icls_e / classify: instruction class used by the DECODE dispatch
//   - alu_phase_e      : datapath phase handed to the ALU-control decoder
//   - ctrl_out_t       : registered per-state control word of the FSM
package mc_ctrl_pkg;

    localparam int ALU_CONTROL_LENGTH = 4;

    localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_ADD  = 4'd0;
    localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_ADDU = 4'd1;
    localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_SUB  = 4'd2;
    localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_SUBU = 4'd3;
    localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_AND  = 4'd4;
    localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_OR   = 4'd5;
    localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_ORI  = 4'd6;
    localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_SLT  = 4'd7;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;

    localparam logic [1:0] ALUSRCB_REG   = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_BROFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        ICLS_R,
        ICLS_MEM,
        ICLS_I,
        ICLS_BEQ,
        ICLS_J,
        ICLS_BAD
    } icls_e;

    typedef enum logic [2:0] {
        ALUPH_IDLE,
        ALUPH_FETCH,
        ALUPH_DECODE,
        ALUPH_ADDR,
        ALUPH_EXEC_R,
        ALUPH_EXEC_I,
        ALUPH_BRANCH
    } alu_phase_e;

    // Moore part of the control word. fetch/branch/jump are not strobes on
    // their own: the top qualifies them with mem_ready / zero to form
    // ir_write and pc_en.
    typedef struct packed {
        logic       fetch;
        logic       branch;
        logic       jump;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       trap;
    } ctrl_out_t;

    // R-type is only legal for addu/subu; every other funct is unsupported.
    function automatic icls_e classify(input logic [5:0] op, input logic [5:0] funct);
        icls_e c;
        c = ICLS_BAD;
        case (op)
            OP_RTYPE: if (funct == FUNCT_ADDU || funct == FUNCT_SUBU) c = ICLS_R;
            OP_LW,
            OP_SW:    c = ICLS_MEM;
            OP_ORI,
            OP_ADDI:  c = ICLS_I;
            OP_BEQ:   c = ICLS_BEQ;
            OP_J:     c = ICLS_J;
            default:  c = ICLS_BAD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational ALU-control decoder for the multi-cycle core.
// Ports:
//   i_phase    - datapath phase of the controller FSM
//   i_op       - IR[31:26]
//   i_funct    - IR[5:0]
//   o_alu_cont - ALU operation (ALU_CONTROL_ADDU when the phase needs nothing)
//   o_ext_op   - immediate extension: 1 sign, 0 zero
module mc_alu_dec
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  alu_phase_e                    i_phase,
    input  logic [OP_W-1:0]               i_op,
    input  logic [OP_W-1:0]               i_funct,
    output logic [ALU_CONTROL_LENGTH-1:0] o_alu_cont,
    output logic                          o_ext_op
);

    always_comb begin
        o_alu_cont = ALU_CONTROL_ADDU;
        o_ext_op   = 1'b0;
        case (i_phase)
            ALUPH_DECODE: o_alu_cont = ALU_CONTROL_ADD;
            ALUPH_ADDR: begin
                o_alu_cont = ALU_CONTROL_ADD;
                o_ext_op   = 1'b1;
            end
            ALUPH_EXEC_R: begin
                if (i_funct == FUNCT_SUBU) o_alu_cont = ALU_CONTROL_SUBU;
                else                       o_alu_cont = ALU_CONTROL_ADDU;
            end
            ALUPH_EXEC_I: begin
                // ori zero-extends its immediate; addi sign-extends.
                if (i_op == OP_ORI) begin
                    o_alu_cont = ALU_CONTROL_ORI;
                    o_ext_op   = 1'b0;
                end else begin
                    o_alu_cont = ALU_CONTROL_ADD;
                    o_ext_op   = 1'b1;
                end
            end
            ALUPH_BRANCH: o_alu_cont = ALU_CONTROL_SUBU;
            default: begin
                o_alu_cont = ALU_CONTROL_ADDU;
                o_ext_op   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller of the mipslite core. Sequences the
// shared ALU, register file, PC and unified memory through
// fetch/decode/execute/memory/writeback.
// Optional feature macro: MC_CTRL_TRAP_EN. When defined an unsupported
// instruction parks the FSM in TRAP (illegal=1, no strobes) until reset;
// otherwise illegal pulses during DECODE and the instruction acts as a NOP.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   op, funct             - IR[31:26], IR[5:0]
//   zero                  - ALU zero flag (branch decision)
//   mem_ready             - memory completes the current read/write this cycle
//   pc_en, ir_write       - PC / IR load enables
//   iord                  - memory address: 0 PC, 1 ALUOut
//   mem_read, mem_write   - memory requests
//   reg_dst, mem_to_reg   - writeback register / data selects
//   reg_write             - register file write
//   alu_src_a, alu_src_b  - ALU input selects
//   ext_op                - immediate extension: 1 sign, 0 zero
//   pc_src                - PC source select
//   alu_cont              - ALU operation
//   illegal               - unsupported instruction detected
//   state                 - current FSM state (debug)
//
// Memory handshake: mem_read / mem_write is a request that stays high from
// the first cycle of FETCH/MEMRD/MEMWR until the cycle in which mem_ready is
// 1; that cycle completes the transfer and the FSM moves on at the next edge.
// mem_ready is ignored whenever no request is asserted.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int OP_W    = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [OP_W-1:0]               op,
    input  logic [OP_W-1:0]               funct,
    input  logic                          zero,
    input  logic                          mem_ready,
    output logic                          pc_en,
    output logic                          iord,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic                          ir_write,
    output logic                          reg_dst,
    output logic                          mem_to_reg,
    output logic                          reg_write,
    output logic                          alu_src_a,
    output logic [1:0]                    alu_src_b,
    output logic                          ext_op,
    output logic [1:0]                    pc_src,
    output logic [ALU_CONTROL_LENGTH-1:0] alu_cont,
    output logic                          illegal,
    output logic [STATE_W-1:0]            state
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC_R,
        S_RTYPE_WB,
        S_EXEC_I,
        S_ITYPE_WB,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_e;

    state_e     r_state;
    state_e     w_next;
    ctrl_out_t  r_out;
    logic       r_is_sw;
    icls_e      w_cls;
    alu_phase_e w_phase;

    // Control word of a state, loaded together with the state itself so the
    // outputs come straight from flops.
    function automatic ctrl_out_t moore_out(input state_e s);
        ctrl_out_t o;
        o = '0;
        case (s)
            S_FETCH: begin
                o.fetch     = 1'b1;
                o.mem_read  = 1'b1;
                o.alu_src_b = ALUSRCB_FOUR;
                o.pc_src    = PCSRC_ALU;
            end
            S_DECODE:   o.alu_src_b = ALUSRCB_BROFF;
            S_MEMADR: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = ALUSRCB_IMM;
            end
            S_MEMRD: begin
                o.mem_read = 1'b1;
                o.iord     = 1'b1;
            end
            S_MEMWB: begin
                o.reg_write  = 1'b1;
                o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                o.mem_write = 1'b1;
                o.iord      = 1'b1;
            end
            S_EXEC_R: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = ALUSRCB_REG;
            end
            S_RTYPE_WB: begin
                o.reg_write = 1'b1;
                o.reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = ALUSRCB_IMM;
            end
            S_ITYPE_WB: o.reg_write = 1'b1;
            S_BRANCH: begin
                o.branch    = 1'b1;
                o.alu_src_a = 1'b1;
                o.alu_src_b = ALUSRCB_REG;
                o.pc_src    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                o.jump   = 1'b1;
                o.pc_src = PCSRC_JUMP;
            end
            S_TRAP:  o.trap = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    assign w_cls = classify(op, funct);

    always_comb begin
        w_next = r_state;
        case (r_state)
            // r_out.fetch is 0 for the first cycle after reset release, so
            // that edge is always spent in FETCH without completing a read.
            S_FETCH:  if (r_out.fetch && mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (w_cls)
                    ICLS_R:   w_next = S_EXEC_R;
                    ICLS_MEM: w_next = S_MEMADR;
                    ICLS_I:   w_next = S_EXEC_I;
                    ICLS_BEQ: w_next = S_BRANCH;
                    ICLS_J:   w_next = S_JUMP;
`ifdef MC_CTRL_TRAP_EN
                    default:  w_next = S_TRAP;
`else
                    default:  w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   w_next = r_is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (mem_ready) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWR:    if (mem_ready) w_next = S_FETCH;
            S_EXEC_R:   w_next = S_RTYPE_WB;
            S_RTYPE_WB: w_next = S_FETCH;
            S_EXEC_I:   w_next = S_ITYPE_WB;
            S_ITYPE_WB: w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
`ifdef MC_CTRL_TRAP_EN
            S_TRAP:     w_next = S_TRAP;
`else
            S_TRAP:     w_next = S_FETCH;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_out   <= '0;
            r_is_sw <= 1'b0;
        end else begin
            r_state <= w_next;
            r_out   <= moore_out(w_next);
            // Remember lw/sw while the opcode is being decoded so MEMADR
            // does not look at op again.
            if (r_state == S_DECODE) r_is_sw <= (op == OP_SW);
        end
    end

    always_comb begin
        w_phase = ALUPH_IDLE;
        case (r_state)
            S_FETCH:  w_phase = ALUPH_FETCH;
            S_DECODE: w_phase = ALUPH_DECODE;
            S_MEMADR: w_phase = ALUPH_ADDR;
            S_EXEC_R: w_phase = ALUPH_EXEC_R;
            S_EXEC_I: w_phase = ALUPH_EXEC_I;
            S_BRANCH: w_phase = ALUPH_BRANCH;
            default:  w_phase = ALUPH_IDLE;
        endcase
    end

    mc_alu_dec #(
        .OP_W(OP_W)
    ) u_alu_dec (
        .i_phase   (w_phase),
        .i_op      (op),
        .i_funct   (funct),
        .o_alu_cont(alu_cont),
        .o_ext_op  (ext_op)
    );

    // IR and PC loads complete only in the cycle memory answers the fetch;
    // a taken beq is decided by the live zero flag of the compare.
    assign ir_write   = r_out.fetch & mem_ready;
    assign pc_en      = (r_out.fetch & mem_ready) | (r_out.branch & zero) | r_out.jump;
    assign iord       = r_out.iord;
    assign mem_read   = r_out.mem_read;
    assign mem_write  = r_out.mem_write;
    assign reg_dst    = r_out.reg_dst;
    assign mem_to_reg = r_out.mem_to_reg;
    assign reg_write  = r_out.reg_write;
    assign alu_src_a  = r_out.alu_src_a;
    assign alu_src_b  = r_out.alu_src_b;
    assign pc_src     = r_out.pc_src;
    // IR is only valid from DECODE on, so the illegal flag of the DECODE
    // cycle is decoded live from op/funct.
    assign illegal    = r_out.trap | ((r_state == S_DECODE) && (w_cls == ICLS_BAD));
    assign state      = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed bench for mc_ctrl. Every cycle of every instruction
// has a hand-written expected control word; the driver pushes it while
// driving the cycle and a monitor pops and compares at the falling edge.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_RTYPE_WB = 4'd7;
    localparam logic [3:0] S_EXEC_I   = 4'd8;
    localparam logic [3:0] S_ITYPE_WB = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    typedef struct packed {
        logic [3:0]                    st;
        logic                          pc_en;
        logic                          iord;
        logic                          mem_read;
        logic                          mem_write;
        logic                          ir_write;
        logic                          reg_dst;
        logic                          mem_to_reg;
        logic                          reg_write;
        logic                          alu_src_a;
        logic [1:0]                    alu_src_b;
        logic                          ext_op;
        logic [1:0]                    pc_src;
        logic [ALU_CONTROL_LENGTH-1:0] alu_cont;
        logic                          illegal;
    } obs_t;
    localparam int OBS_W = $bits(obs_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic zero = 1'b0;
    logic mem_ready = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;

    always #5 clk = ~clk;

    logic                          pc_en, iord, mem_read, mem_write, ir_write;
    logic                          reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]                    alu_src_b, pc_src;
    logic                          ext_op, illegal;
    logic [ALU_CONTROL_LENGTH-1:0] alu_cont;
    logic [3:0]                    state;

    mc_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_en     (pc_en),
        .iord      (iord),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .ir_write  (ir_write),
        .reg_dst   (reg_dst),
        .mem_to_reg(mem_to_reg),
        .reg_write (reg_write),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .ext_op    (ext_op),
        .pc_src    (pc_src),
        .alu_cont  (alu_cont),
        .illegal   (illegal),
        .state     (state)
    );

    obs_t got;
    assign got = {state, pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_op, pc_src,
                  alu_cont, illegal};

    // ---------------- scoreboard ----------------
    logic [OBS_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int n_cyc = 0;
    obs_t m_exp;

    initial begin
        forever begin
            @(negedge clk);
            n_cyc++;
            if (exp_q.size() > 0) begin
                m_exp = obs_t'(exp_q.pop_front());
                n_cmp++;
                if (got !== m_exp) begin
                    n_fail++;
                    $display("FAIL ctrl_word cyc=%0d st=%0d: got %h want %h (want st=%0d)",
                             n_cyc, got.st, got, m_exp, m_exp.st);
                end
                n_cmp++;
                if (mem_read && mem_write) begin
                    n_fail++;
                    $display("FAIL rw_exclusive cyc=%0d: got rd=%b wr=%b want not both",
                             n_cyc, mem_read, mem_write);
                end
            end
        end
    end

    // ---------------- expected control words ----------------
    function automatic obs_t rst_row();
        obs_t r;
        r = '0;
        r.st = S_FETCH;
        r.alu_cont = ALU_CONTROL_ADDU;
        return r;
    endfunction

    // Input-independent outputs of each state; callers add pc_en/ir_write
    // and the instruction-dependent ALU fields.
    function automatic obs_t row(input logic [3:0] st);
        obs_t r;
        r = '0;
        r.st = st;
        r.alu_cont = ALU_CONTROL_ADDU;
        case (st)
            S_FETCH:    begin r.mem_read = 1'b1; r.alu_src_b = 2'b01; end
            S_DECODE:   begin r.alu_src_b = 2'b11; r.alu_cont = ALU_CONTROL_ADD; end
            S_MEMADR:   begin r.alu_src_a = 1'b1; r.alu_src_b = 2'b10; r.ext_op = 1'b1;
                              r.alu_cont = ALU_CONTROL_ADD; end
            S_MEMRD:    begin r.mem_read = 1'b1; r.iord = 1'b1; end
            S_MEMWB:    begin r.reg_write = 1'b1; r.mem_to_reg = 1'b1; end
            S_MEMWR:    begin r.mem_write = 1'b1; r.iord = 1'b1; end
            S_EXEC_R:   r.alu_src_a = 1'b1;
            S_RTYPE_WB: begin r.reg_write = 1'b1; r.reg_dst = 1'b1; end
            S_EXEC_I:   begin r.alu_src_a = 1'b1; r.alu_src_b = 2'b10; end
            S_ITYPE_WB: r.reg_write = 1'b1;
            S_BRANCH:   begin r.alu_src_a = 1'b1; r.pc_src = 2'b01;
                              r.alu_cont = ALU_CONTROL_SUBU; end
            S_JUMP:     begin r.pc_src = 2'b10; r.pc_en = 1'b1; end
            S_TRAP:     r.illegal = 1'b1;
            default:    r = '0;
        endcase
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic mr, input logic z, input obs_t e);
        mem_ready = mr;
        zero = z;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b1, 1'b0, rst_row());
        cyc(1'b1, 1'b0, rst_row());
        rst_n = 1'b1;
        // Release cycle: still in FETCH with strobes low even though mem_ready=1.
        cyc(1'b1, 1'b0, rst_row());
    endtask

    task automatic fetch(input logic [5:0] o, input logic [5:0] f, input int waits);
        obs_t e;
        for (int i = 0; i < waits; i++) cyc(1'b0, 1'b0, row(S_FETCH));
        op = o;
        funct = f;
        e = row(S_FETCH);
        e.pc_en = 1'b1;
        e.ir_write = 1'b1;
        cyc(1'b1, 1'b0, e);
    endtask

    task automatic decode(input logic bad);
        obs_t e;
        e = row(S_DECODE);
        e.illegal = bad;
        cyc(1'b1, 1'b0, e);
    endtask

    task automatic run_rtype(input logic [5:0] f, input logic [ALU_CONTROL_LENGTH-1:0] alu);
        obs_t e;
        fetch(OP_RTYPE, f, 0);
        decode(1'b0);
        e = row(S_EXEC_R);
        e.alu_cont = alu;
        cyc(1'b1, 1'b0, e);
        cyc(1'b1, 1'b0, row(S_RTYPE_WB));
    endtask

    task automatic run_itype(input logic [5:0] o, input logic ext,
                             input logic [ALU_CONTROL_LENGTH-1:0] alu);
        obs_t e;
        fetch(o, 6'b010101, 0);
        decode(1'b0);
        e = row(S_EXEC_I);
        e.ext_op = ext;
        e.alu_cont = alu;
        cyc(1'b1, 1'b0, e);
        cyc(1'b1, 1'b0, row(S_ITYPE_WB));
    endtask

    task automatic run_beq(input logic z);
        obs_t e;
        fetch(OP_BEQ, 6'b000000, 0);
        decode(1'b0);
        e = row(S_BRANCH);
        e.pc_en = z;
        cyc(1'b1, z, e);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        obs_t e;
        @(posedge clk);
        #1;
        do_reset();

        // addu / subu
        run_rtype(FUNCT_ADDU, ALU_CONTROL_ADDU);
        run_rtype(FUNCT_SUBU, ALU_CONTROL_SUBU);

        // lw: 2 fetch waits, 3 read waits -> 10 cycles
        fetch(OP_LW, 6'b000100, 2);
        decode(1'b0);
        cyc(1'b1, 1'b0, row(S_MEMADR));
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, row(S_MEMRD));
        cyc(1'b1, 1'b0, row(S_MEMRD));
        cyc(1'b1, 1'b0, row(S_MEMWB));

        // beq taken / not taken, then j
        run_beq(1'b1);
        run_beq(1'b0);
        fetch(OP_J, 6'b111000, 0);
        decode(1'b0);
        cyc(1'b1, 1'b0, row(S_JUMP));

        // ori zero-extends, addi sign-extends
        run_itype(OP_ORI, 1'b0, ALU_CONTROL_ORI);
        run_itype(OP_ADDI, 1'b1, ALU_CONTROL_ADD);

        // sw with mem_ready high: one mem_write cycle
        fetch(OP_SW, 6'b000000, 0);
        decode(1'b0);
        cyc(1'b1, 1'b0, row(S_MEMADR));
        cyc(1'b1, 1'b0, row(S_MEMWR));

        // sw with one write wait, then reset during the second wait cycle
        fetch(OP_SW, 6'b000000, 0);
        decode(1'b0);
        cyc(1'b1, 1'b0, row(S_MEMADR));
        cyc(1'b0, 1'b0, row(S_MEMWR));
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, rst_row());
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, rst_row());
        cyc(1'b0, 1'b0, row(S_FETCH));
        run_rtype(FUNCT_ADDU, ALU_CONTROL_ADDU);

`ifndef MC_CTRL_TRAP_EN
        // Unsupported R-type funct behaves as a NOP
        fetch(OP_RTYPE, 6'b100000, 0);
        decode(1'b1);
        cyc(1'b0, 1'b0, row(S_FETCH));
`endif

        // Illegal opcode 111111
        fetch(6'b111111, 6'b000000, 0);
        decode(1'b1);
`ifdef MC_CTRL_TRAP_EN
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, row(S_TRAP));
        do_reset();
`else
        cyc(1'b0, 1'b0, row(S_FETCH));
`endif
        run_rtype(FUNCT_SUBU, ALU_CONTROL_SUBU);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
